// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_pkg
// Purpose : Shared types, FSM state constants and the helper that extracts the
//           destination field for the NoC input controller.
// Rev     : 1.0  initial release
// ============================================================================
package noc_pkg;

  localparam int DEF_WIDTH_PACKET = 14;
  localparam int DEF_WIDTH_ADDR   = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FWD  = 2'd1;
  localparam state_t ST_SEND = 2'd2;
  localparam state_t ST_BACK = 2'd3;

  // Destination field sits in the most significant bits of the packet.
  function automatic logic [31:0] get_dest(input logic [63:0] pkt,
                                           input int          wp,
                                           input int          wd);
    logic [63:0] sh;
    sh = pkt >> (wp - wd);
    return sh[31:0] & ((32'd1 << wd) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_route_decode.sv
`default_nettype none
// ============================================================================
// Module  : noc_route_decode
// Purpose : Combinational destination -> output-select decode.
//           sel = 0 selects out1, sel = 1 selects out2.
// Rev     : 1.0  initial release
// ============================================================================
module noc_route_decode #(
  parameter int                    WIDTH_dest = 3,
  parameter logic [WIDTH_dest-1:0] MASK       = 3'b110,
  parameter logic [WIDTH_dest-1:0] ADDR       = 3'b000,
  parameter int                    LEVEL      = 0,
  parameter bit                    is_parent  = 1'b0
) (
  input  logic [WIDTH_dest-1:0] dest,
  output logic                  sel
);

  // Tree level selects which destination bit steers a downward packet;
  // clamped so an out-of-range LEVEL never produces an illegal index.
  localparam int SEL_BIT = (LEVEL >= 0 && LEVEL < WIDTH_dest) ? (WIDTH_dest - 1 - LEVEL) : 0;

  // Downward: steer on one address bit. Upward: stay in subtree if prefix matches.
  always_comb begin
    sel = 1'b0;
    if (is_parent) begin
      sel = dest[SEL_BIT];
    end else begin
      sel = ((dest & MASK) != (ADDR & MASK));
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : noc_input_ctrl
// Purpose : Single-slot router input controller. Accepts one packet, routes it
//           to out1/out2, models FL cycles of forward latency and BL cycles of
//           backward recovery before accepting the next packet.
// Rev     : 1.0  initial release
// ============================================================================
module noc_input_ctrl
  import noc_pkg::*;
#(
  parameter int                    WIDTH_packet = DEF_WIDTH_PACKET,
  parameter int                    WIDTH_dest   = DEF_WIDTH_ADDR,
  parameter int                    WIDTH_addr   = DEF_WIDTH_ADDR,
  parameter int                    FL           = 2,
  parameter int                    BL           = 1,
  parameter logic [WIDTH_addr-1:0] MASK         = 3'b110,
  parameter int                    LEVEL        = 0,
  parameter bit                    is_parent    = 1'b0,
  parameter int                    NUM_NODE     = 8,
  parameter logic [WIDTH_addr-1:0] ADDR         = 3'b000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH_packet-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH_packet-1:0] out1_data,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic [WIDTH_packet-1:0] out2_data,
  output logic                    out2_valid,
  input  logic                    out2_ready
);

  // Parameter sanity: the address space must be fully populated.
  if (NUM_NODE != 2 ** WIDTH_addr) begin : g_chk_num_node
    $error("noc_input_ctrl: NUM_NODE must equal 2**WIDTH_addr");
  end
  if (WIDTH_dest != WIDTH_addr) begin : g_chk_dest_width
    $error("noc_input_ctrl: WIDTH_dest must equal WIDTH_addr");
  end
  if (FL < 1 || BL < 0) begin : g_chk_latency
    $error("noc_input_ctrl: FL must be >= 1 and BL >= 0");
  end

  localparam int CNT_W     = $clog2(FL + BL + 2);
  localparam int FWD_LAST  = (FL >= 2) ? (FL - 2) : 0;
  localparam int BACK_LAST = (BL >= 1) ? (BL - 1) : 0;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH_packet-1:0] pkt;
  logic                    route;
  logic                    ready_armed;
  logic [WIDTH_dest-1:0]   dest;
  logic                    route_next;
  logic                    in_fire;
  logic                    out_fire;
  logic                    sending;

  assign dest = WIDTH_dest'(get_dest(64'(in_data), WIDTH_packet, WIDTH_dest));

  noc_route_decode #(
    .WIDTH_dest (WIDTH_dest),
    .MASK       (MASK),
    .ADDR       (ADDR),
    .LEVEL      (LEVEL),
    .is_parent  (is_parent)
  ) u_route_decode (
    .dest (dest),
    .sel  (route_next)
  );

  // Outputs derive from state so an asynchronous reset clears them at once.
  always_comb begin
    sending    = (state == ST_SEND);
    in_ready   = ready_armed && (state == ST_IDLE);
    out1_valid = sending && !route;
    out2_valid = sending && route;
    out1_data  = out1_valid ? pkt : '0;
    out2_data  = out2_valid ? pkt : '0;
    in_fire    = in_valid && in_ready;
    out_fire   = (out1_valid && out1_ready) || (out2_valid && out2_ready);
  end

  // Handshake FSM: accept -> forward delay -> present -> recovery -> accept.
  // ready_armed holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pkt         <= '0;
      route       <= 1'b0;
      ready_armed <= 1'b0;
    end else begin
      ready_armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            pkt   <= in_data;
            route <= route_next;
            cnt   <= '0;
            state <= (FL == 1) ? ST_SEND : ST_FWD;
          end
        end
        ST_FWD: begin
          if (cnt == CNT_W'(FWD_LAST)) begin
            cnt   <= '0;
            state <= ST_SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (out_fire) begin
            cnt   <= '0;
            state <= (BL == 0) ? ST_IDLE : ST_BACK;
          end
        end
        ST_BACK: begin
          if (cnt == CNT_W'(BACK_LAST)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_noc_input_ctrl
// Purpose : Scoreboard bench for noc_input_ctrl (child-port config) plus two
//           parent-port instances for downward routing.
// Rev     : 1.0  initial release
// ============================================================================
module tb_noc_input_ctrl;

  localparam int W  = 14;
  localparam int FL = 2;
  localparam int BL = 1;

  typedef struct {
    logic [W-1:0] data;
    bit           chan;   // 0 = out1, 1 = out2
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out1_data, out2_data;
  logic         out1_valid, out2_valid;
  logic         out1_ready = 1'b0, out2_ready = 1'b0;

  logic [W-1:0] p_data = '0;
  logic         p_valid = 1'b0;
  logic         p2_ready, p0_ready;
  logic [W-1:0] p2_o1d, p2_o2d, p0_o1d, p0_o2d;
  logic         p2_o1v, p2_o2v, p0_o1v, p0_o2v;

  int   vectors = 0;
  int   miscompares = 0;
  int   edges = 0;
  exp_t q[$];
  bit   busy = 1'b0;
  int   due = 0;
  int   free_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  noc_input_ctrl #(
    .WIDTH_packet(W), .WIDTH_dest(3), .WIDTH_addr(3), .FL(FL), .BL(BL),
    .MASK(3'b110), .LEVEL(2), .is_parent(1'b0), .NUM_NODE(8), .ADDR(3'b000)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready)
  );

  noc_input_ctrl #(
    .WIDTH_packet(W), .FL(FL), .BL(BL), .LEVEL(2), .is_parent(1'b1)
  ) p2 (
    .clk(clk), .rst(rst),
    .in_data(p_data), .in_valid(p_valid), .in_ready(p2_ready),
    .out1_data(p2_o1d), .out1_valid(p2_o1v), .out1_ready(1'b1),
    .out2_data(p2_o2d), .out2_valid(p2_o2v), .out2_ready(1'b1)
  );

  noc_input_ctrl #(
    .WIDTH_packet(W), .FL(FL), .BL(BL), .LEVEL(0), .is_parent(1'b1)
  ) p0 (
    .clk(clk), .rst(rst),
    .in_data(p_data), .in_valid(p_valid), .in_ready(p0_ready),
    .out1_data(p0_o1d), .out1_valid(p0_o1v), .out1_ready(1'b1),
    .out2_data(p0_o2d), .out2_valid(p0_o2v), .out2_ready(1'b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Child-port router with ADDR=000, MASK=110: leaves 0 and 1 share the
  // subtree, every other leaf goes up.
  function automatic bit child_chan(input logic [W-1:0] d);
    int leaf;
    leaf = int'(d) / (1 << (W - 3));
    return (leaf / 2 == 0) ? 1'b0 : 1'b1;
  endfunction

  // Parent-port router: leaf address bit (2 - level) picks child 0 or 1.
  function automatic bit parent_chan(input logic [W-1:0] d, input int level);
    int leaf;
    leaf = int'(d) / (1 << (W - 3));
    return ((leaf / (1 << (2 - level))) % 2) == 1;
  endfunction

  // Monitor / reference model for the main DUT, sampled mid-cycle.
  always @(negedge clk) begin
    bit           exp_ready, show;
    exp_t         h;
    if (rst) begin
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_valids", {30'd0, out1_valid, out2_valid}, 0);
      check("rst_data", 32'(out1_data | out2_data), 0);
      q.delete();
      busy      = 1'b0;
      free_edge = edges + 1;
    end else begin
      exp_ready = !busy && (edges >= free_edge);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      show = busy && (edges >= due) && (q.size() > 0);
      h.data = '0;
      h.chan = 1'b0;
      if (q.size() > 0) h = q[0];
      check("out1_valid", 32'(out1_valid), 32'(show && !h.chan));
      check("out2_valid", 32'(out2_valid), 32'(show && h.chan));
      check("out1_data", 32'(out1_data), (show && !h.chan) ? 32'(h.data) : 0);
      check("out2_data", 32'(out2_data), (show && h.chan) ? 32'(h.data) : 0);
      if (show && ((!h.chan && out1_ready) || (h.chan && out2_ready))) begin
        void'(q.pop_front());
        busy      = 1'b0;
        free_edge = edges + 1 + BL;
      end else if (exp_ready && in_valid) begin
        h.data = in_data;
        h.chan = child_chan(in_data);
        q.push_back(h);
        busy = 1'b1;
        due  = edges + FL;
      end
    end
  end

  task automatic send_main(input logic [W-1:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic parent_send(input logic [2:0] dest);
    logic [W-1:0] d;
    bit c2, c0;
    d  = {dest, 11'(($urandom & 32'h7ff))};
    c2 = parent_chan(d, 2);
    c0 = parent_chan(d, 0);
    @(posedge clk); #1;
    p_data  = d;
    p_valid = 1'b1;
    @(negedge clk);
    check("p_in_ready", {30'd0, p2_ready, p0_ready}, 32'h3);
    @(posedge clk); #1;
    p_valid = 1'b0;
    repeat (FL - 1) @(posedge clk);
    @(negedge clk);
    check("p2_valids", {30'd0, p2_o1v, p2_o2v}, c2 ? 32'h1 : 32'h2);
    check("p2_data", 32'(p2_o1d | p2_o2d), 32'(d));
    check("p0_valids", {30'd0, p0_o1v, p0_o2v}, c0 ? 32'h1 : 32'h2);
    check("p0_data", 32'(p0_o1d | p0_o2d), 32'(d));
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;

    // Downward routing on parent-port instances.
    parent_send(3'b011);
    parent_send(3'b010);
    parent_send(3'b100);
    parent_send(3'b001);

    // Directed child-port routing with exact latency.
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    send_main(14'b001_00000000101);
    send_main(14'b101_00000000011);
    send_main(14'b000_00000000111);
    repeat (6) @(posedge clk);

    // Back-pressure: out1 stalled for more than ten cycles.
    out1_ready = 1'b0;
    send_main(14'b000_10101010101);
    repeat (12) @(posedge clk);
    #1 out1_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = W'($urandom);
      out1_ready = $urandom_range(0, 3) != 0;
      out2_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Reset while a packet is being presented: it must never be delivered.
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    send_main(14'b110_00110011001);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out1_valid || out2_valid) seen = 1'b1;
    end
    check("reset_setup_send", 32'(seen), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_valids", {30'd0, out1_valid, out2_valid}, 0);
    check("async_data", 32'(out1_data | out2_data), 0);
    check("async_in_ready", 32'(in_ready), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 0);
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    repeat (10) @(posedge clk);
    send_main(14'b010_00000000001);
    repeat (6) @(posedge clk);
    check("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
